// File: rtl/rv32i_types.sv
// Shared types for the data-memory scheduler.
//   ld_st_sched_state_t : scheduler FSM states
//   dmem_req_t          : one data-memory request (address, masks, write data)
//   word_align()        : byte address -> word-aligned address
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LD_WAIT    = 2'd1,
    ST_WAIT    = 2'd2,
    LD_DISCARD = 2'd3
  } ld_st_sched_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ld_st_mem_sched.sv
// Scheduler for the single data-memory port, shared between the load path
// and the head of the committed-store FIFO. One transaction is outstanding
// at a time. Loads normally win, but a store at commit is forced through
// after STARVE_MAX consecutive load wins over it. Load responses that
// belong to a flushed load are dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               pipeline flush (kills a pending load result)
//   st_*                store FIFO head: valid, ready, ROB index, addr/data/mask
//   rob_head_idx        current ROB head, a store issues only at commit
//   st_pop              one-cycle read enable to the store FIFO
//   ld_valid/addr/rmask load request
//   ld_grant            load accepted (pulses with the read request)
//   ld_done/ld_rdata    load data return, one cycle
//   dmem_*              memory request/response; masks nonzero for one cycle
module ld_st_mem_sched
  import rv32i_types::*;
#(
  parameter int ROB_IDX_W  = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 st_valid,
  input  logic                 st_ready,
  input  logic [ROB_IDX_W-1:0] st_rob_idx,
  input  logic [31:0]          st_addr,
  input  logic [31:0]          st_wdata,
  input  logic [3:0]           st_wmask,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  output logic                 st_pop,
  input  logic                 ld_valid,
  input  logic [31:0]          ld_addr,
  input  logic [3:0]           ld_rmask,
  output logic                 ld_grant,
  output logic                 ld_done,
  output logic [31:0]          ld_rdata,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  ld_st_sched_state_t state, state_next;
  dmem_req_t          req, req_next;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_next;
  logic               st_eligible, ld_win, st_win;
  logic               ld_done_next, st_pop_next;

  assign st_eligible = st_valid && st_ready && (st_rob_idx == rob_head_idx);
  assign ld_win = (state == IDLE) && ld_valid && !flush &&
                  (!st_eligible || (starve_cnt < CNT_MAX));
  assign st_win = (state == IDLE) && st_eligible && !ld_win;

  // A load result is delivered only if no flush arrived at any point
  // while it was outstanding, including the response cycle itself.
  assign ld_done_next = (state == LD_WAIT) && dmem_resp && !flush;
  assign st_pop_next  = (state == ST_WAIT) && dmem_resp;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ld_win)      state_next = LD_WAIT;
        else if (st_win) state_next = ST_WAIT;
      end
      LD_WAIT: begin
        if (dmem_resp)  state_next = IDLE;
        else if (flush) state_next = LD_DISCARD;
      end
      ST_WAIT:    if (dmem_resp) state_next = IDLE;
      LD_DISCARD: if (dmem_resp) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Address and write data hold their last value; only the masks are
  // pulsed, so the request is visible for exactly one cycle.
  always_comb begin
    req_next       = req;
    req_next.rmask = 4'b0000;
    req_next.wmask = 4'b0000;
    if (ld_win) begin
      req_next.addr  = word_align(ld_addr);
      req_next.rmask = ld_rmask;
    end else if (st_win) begin
      req_next.addr  = word_align(st_addr);
      req_next.wmask = st_wmask;
      req_next.wdata = st_wdata;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (st_win)
      starve_cnt_next = '0;
    else if (ld_win && st_eligible && (starve_cnt < CNT_MAX))
      starve_cnt_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req        <= '0;
      starve_cnt <= '0;
      ld_grant   <= 1'b0;
      ld_done    <= 1'b0;
      ld_rdata   <= 32'h0;
      st_pop     <= 1'b0;
    end else begin
      state      <= state_next;
      req        <= req_next;
      starve_cnt <= starve_cnt_next;
      ld_grant   <= ld_win;
      ld_done    <= ld_done_next;
      st_pop     <= st_pop_next;
      if (ld_done_next) ld_rdata <= dmem_rdata;
    end
  end

  assign dmem_addr  = req.addr;
  assign dmem_rmask = req.rmask;
  assign dmem_wmask = req.wmask;
  assign dmem_wdata = req.wdata;

  // A response with nothing outstanding indicates a broken memory model.
  resp_in_idle_a: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && dmem_resp));

endmodule
